// File: rtl/ps2_host_pkg.sv
`default_nettype none
// ps2_host_pkg -- state encoding and PS/2 command/response bytes for ps2_host_ctrl.
// Rev 1.0. The init states exist only when PS2_HOST_INIT_EN is defined.
package ps2_host_pkg;

  localparam logic [7:0] CMD_LED      = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_CMD = 3'd1,
    ST_WAIT_CMD = 3'd2,
    ST_SEND_ARG = 3'd3,
    ST_WAIT_ARG = 3'd4
`ifdef PS2_HOST_INIT_EN
    ,
    ST_SEND_RST = 3'd5,
    ST_WAIT_RST = 3'd6,
    ST_WAIT_BAT = 3'd7
`endif
  } state_t;

  // States in which the keyboard's FA/FE replies are consumed rather than forwarded.
  function automatic logic is_wait(input state_t s);
    logic w;
    w = 1'b0;
    case (s)
      ST_WAIT_CMD, ST_WAIT_ARG: w = 1'b1;
`ifdef PS2_HOST_INIT_EN
      ST_WAIT_RST, ST_WAIT_BAT: w = 1'b1;
`endif
      default: w = 1'b0;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_ack_timer.sv
`default_nettype none
// ps2_ack_timer -- saturating response timeout counter; expired holds at CYCLES-1.
// Rev 1.0.
module ps2_ack_timer #(
  parameter int WIDTH  = 24,
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(CYCLES - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/ps2_host_ctrl.sv
`default_nettype none
// ps2_host_ctrl -- PS/2 keyboard host: LED update sequence with retry/timeout, scan-code forwarding.
// Rev 1.0. Define PS2_HOST_INIT_EN to add the power-on reset/BAT handshake.
module ps2_host_ctrl
  import ps2_host_pkg::*;
#(
  parameter int timeoutBits   = 24,
  parameter int timeoutCycles = 1000000,
  parameter int maxRetries    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rxData,
  input  logic       rxValid,
  input  logic       txBusy,
  output logic [7:0] txByte,
  output logic       txStart,
  input  logic       ledReq,
  input  logic [2:0] leds,
  output logic [7:0] keyData,
  output logic       keyValid,
  output logic       busy,
  output logic       error
);

  localparam logic [7:0] RETRY_LIMIT = 8'(maxRetries);
`ifdef PS2_HOST_INIT_EN
  localparam state_t RESET_STATE = ST_SEND_RST;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t     state;
  state_t     ack_state;
  state_t     resend_state;
  logic       pending;
  logic [7:0] retry_cnt;
  logic       rx_ack;
  logic       rx_resend;
  logic       rx_consumed;
  logic       timer_clear;
  logic       timer_enable;
  logic       timer_expired;
`ifdef PS2_HOST_INIT_EN
  logic       rx_bat_ok;
  logic       rx_bat_fail;
`endif

  always_comb begin
    rx_ack       = rxValid && (rxData == RSP_ACK);
    rx_resend    = rxValid && (rxData == RSP_RESEND);
    rx_consumed  = is_wait(state) && (rx_ack || rx_resend);
    timer_enable = is_wait(state);
    timer_clear  = (state == ST_SEND_CMD) || (state == ST_SEND_ARG);
`ifdef PS2_HOST_INIT_EN
    rx_bat_ok   = rxValid && (rxData == RSP_BAT_OK);
    rx_bat_fail = rxValid && (rxData == RSP_BAT_FAIL);
    if ((state == ST_WAIT_BAT) && (rx_bat_ok || rx_bat_fail)) rx_consumed = 1'b1;
    // The BAT wait gets a fresh timeout window once FF is acknowledged.
    if ((state == ST_SEND_RST) || ((state == ST_WAIT_RST) && rx_ack)) timer_clear = 1'b1;
`endif
  end

  always_comb begin
    ack_state    = ST_SEND_ARG;
    resend_state = ST_SEND_CMD;
    case (state)
      ST_WAIT_ARG: begin
        ack_state    = ST_IDLE;
        resend_state = ST_SEND_ARG;
      end
`ifdef PS2_HOST_INIT_EN
      ST_WAIT_RST: begin
        ack_state    = ST_WAIT_BAT;
        resend_state = ST_SEND_RST;
      end
`endif
      default: begin
        ack_state    = ST_SEND_ARG;
        resend_state = ST_SEND_CMD;
      end
    endcase
  end

  ps2_ack_timer #(
    .WIDTH  (timeoutBits),
    .CYCLES (timeoutCycles)
  ) u_ack_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RESET_STATE;
      txStart   <= 1'b0;
      txByte    <= 8'h00;
      keyValid  <= 1'b0;
      keyData   <= 8'h00;
      error     <= 1'b0;
      pending   <= 1'b0;
      retry_cnt <= 8'h00;
    end else begin
      txStart  <= 1'b0;
      keyValid <= 1'b0;
      if (rxValid && !rx_consumed) begin
        keyData  <= rxData;
        keyValid <= 1'b1;
      end
      if (ledReq && (state != ST_IDLE)) pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (ledReq || pending) begin
            state     <= ST_SEND_CMD;
            error     <= 1'b0;
            pending   <= 1'b0;
            retry_cnt <= 8'h00;
          end
        end
        ST_SEND_CMD: begin
          if (!txBusy) begin
            txStart <= 1'b1;
            txByte  <= CMD_LED;
            state   <= ST_WAIT_CMD;
          end
        end
        ST_SEND_ARG: begin
          if (!txBusy) begin
            txStart <= 1'b1;
            txByte  <= {5'b00000, leds};
            state   <= ST_WAIT_ARG;
          end
        end
`ifdef PS2_HOST_INIT_EN
        ST_SEND_RST: begin
          if (!txBusy) begin
            txStart <= 1'b1;
            txByte  <= CMD_RESET;
            state   <= ST_WAIT_RST;
          end
        end
        ST_WAIT_BAT: begin
          if (rx_bat_ok) begin
            state <= ST_IDLE;
          end else if (rx_bat_fail || timer_expired) begin
            error <= 1'b1;
            state <= ST_IDLE;
          end
        end
`endif
        ST_WAIT_CMD, ST_WAIT_ARG
`ifdef PS2_HOST_INIT_EN
        , ST_WAIT_RST
`endif
        : begin
          // A reply byte wins over a timeout expiring in the same cycle.
          if (rx_ack) begin
            retry_cnt <= 8'h00;
            state     <= ack_state;
          end else if (rx_resend) begin
            if (retry_cnt == RETRY_LIMIT) begin
              error <= 1'b1;
              state <= ST_IDLE;
            end else begin
              retry_cnt <= retry_cnt + 8'd1;
              state     <= resend_state;
            end
          end else if (timer_expired) begin
            error <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_ctrl.sv
`default_nettype none
// tb_ps2_host_ctrl -- directed self-checking bench for ps2_host_ctrl (timeoutCycles=100, maxRetries=3).
// Rev 1.0.
module tb_ps2_host_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rxData = 8'h00;
  logic       rxValid = 1'b0;
  logic       txBusy = 1'b0;
  logic       ledReq = 1'b0;
  logic [2:0] leds = 3'b101;
  logic [7:0] txByte;
  logic       txStart;
  logic [7:0] keyData;
  logic       keyValid;
  logic       busy;
  logic       error;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  logic [7:0] key_q[$];

  always #5 clk = ~clk;

  ps2_host_ctrl #(
    .timeoutBits   (24),
    .timeoutCycles (100),
    .maxRetries    (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .txBusy   (txBusy),
    .txByte   (txByte),
    .txStart  (txStart),
    .ledReq   (ledReq),
    .leds     (leds),
    .keyData  (keyData),
    .keyValid (keyValid),
    .busy     (busy),
    .error    (error)
  );

  always @(negedge clk) begin
    if (txStart) tx_q.push_back(txByte);
    if (keyValid) key_q.push_back(keyData);
  end

  function automatic logic [7:0] tx_at(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 8'hxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_led();
    ledReq = 1'b1;
    tick(1);
    ledReq = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    tick(1);
    rxValid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 300; i++) begin
      if (tx_q.size() >= n) break;
      tick(1);
    end
  endtask

  task automatic wait_txstart(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (txStart === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic clear_q();
    tx_q.delete();
    key_q.delete();
  endtask

`ifdef PS2_HOST_INIT_EN
  task automatic finish_init();
    wait_tx(1);
    tick(2);
    send_rx(8'hFA);
    tick(2);
    send_rx(8'hAA);
    tick(2);
    clear_q();
  endtask
`endif

  task automatic test_reset();
    logic exp_busy;
`ifdef PS2_HOST_INIT_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    reset = 1'b1;
    tick(3);
    n_cmp++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL reset_txStart: got %b expected 0", txStart); end
    n_cmp++; if (txByte !== 8'h00) begin n_fail++; $display("FAIL reset_txByte: got %h expected 00", txByte); end
    n_cmp++; if (keyValid !== 1'b0) begin n_fail++; $display("FAIL reset_keyValid: got %b expected 0", keyValid); end
    n_cmp++; if (keyData !== 8'h00) begin n_fail++; $display("FAIL reset_keyData: got %h expected 00", keyData); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", busy, exp_busy); end
    reset = 1'b0;
    clear_q();
`ifdef PS2_HOST_INIT_EN
    finish_init();
`endif
  endtask

`ifdef PS2_HOST_INIT_EN
  task automatic test_init();
    clear_q();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    clear_q();
    wait_tx(1);
    n_cmp++; if (tx_at(0) !== 8'hFF) begin n_fail++; $display("FAIL init_ff: got %h expected FF", tx_at(0)); end
    tick(2);
    send_rx(8'hFA);
    tick(3);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL init_busy_bat: got %b expected 1", busy); end
    send_rx(8'hAA);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_after_aa: got %b expected 0", busy); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL init_error_ok: got %b expected 0", error); end
    n_cmp++; if (tx_q.size() !== 1) begin n_fail++; $display("FAIL init_ff_count: got %0d expected 1", tx_q.size()); end
    n_cmp++; if (key_q.size() !== 0) begin n_fail++; $display("FAIL init_no_forward: got %0d expected 0", key_q.size()); end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    clear_q();
    wait_tx(1);
    tick(2);
    send_rx(8'hFA);
    tick(2);
    send_rx(8'hFC);
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL init_bat_fail_error: got %b expected 1", error); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_bat_fail_busy: got %b expected 0", busy); end
  endtask
`endif

  task automatic test_led_update();
    clear_q();
    leds = 3'b101;
    pulse_led();
    wait_tx(1);
    n_cmp++; if (tx_at(0) !== 8'hED) begin n_fail++; $display("FAIL led_cmd: got %h expected ED", tx_at(0)); end
    tick(2);
    send_rx(8'hFA);
    wait_tx(2);
    n_cmp++; if (tx_at(1) !== 8'h05) begin n_fail++; $display("FAIL led_arg: got %h expected 05", tx_at(1)); end
    tick(2);
    send_rx(8'hFA);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL led_busy: got %b expected 0", busy); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL led_error: got %b expected 0", error); end
    n_cmp++; if (key_q.size() !== 0) begin n_fail++; $display("FAIL led_no_forward: got %0d expected 0", key_q.size()); end
  endtask

  task automatic test_resend();
    clear_q();
    pulse_led();
    wait_tx(1);
    tick(2);
    send_rx(8'hFE);
    wait_tx(2);
    tick(2);
    send_rx(8'hFA);
    wait_tx(3);
    tick(2);
    send_rx(8'hFA);
    tick(1);
    n_cmp++; if (tx_at(0) !== 8'hED) begin n_fail++; $display("FAIL resend_b0: got %h expected ED", tx_at(0)); end
    n_cmp++; if (tx_at(1) !== 8'hED) begin n_fail++; $display("FAIL resend_b1: got %h expected ED", tx_at(1)); end
    n_cmp++; if (tx_at(2) !== 8'h05) begin n_fail++; $display("FAIL resend_b2: got %h expected 05", tx_at(2)); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL resend_error: got %b expected 0", error); end
  endtask

  task automatic test_retry_exhaust();
    clear_q();
    pulse_led();
    wait_tx(1);
    for (int i = 0; i < 4; i++) begin
      tick(2);
      send_rx(8'hFE);
      if (i < 3) wait_tx(i + 2);
    end
    tick(5);
    n_cmp++; if (tx_q.size() !== 4) begin n_fail++; $display("FAIL retry_count: got %0d expected 4", tx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tx_at(i) !== 8'hED) begin n_fail++; $display("FAIL retry_byte%0d: got %h expected ED", i, tx_at(i)); end
    end
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL retry_error: got %b expected 1", error); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL retry_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_q();
    pulse_led();
    wait_txstart(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL timeout_start: got %b expected 1", ok); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL timeout_error_cleared: got %b expected 0", error); end
    tick(99);
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", error); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_early: got %b expected 1", busy); end
    tick(1);
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b expected 1", error); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got %b expected 0", busy); end
  endtask

  task automatic test_ack_at_expiry();
    bit ok;
    clear_q();
    leds = 3'b101;
    pulse_led();
    wait_txstart(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL expiry_start: got %b expected 1", ok); end
    tick(99);
    send_rx(8'hFA);
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL expiry_ack_error: got %b expected 0", error); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL expiry_ack_busy: got %b expected 1", busy); end
    wait_tx(2);
    n_cmp++; if (tx_at(1) !== 8'h05) begin n_fail++; $display("FAIL expiry_arg: got %h expected 05", tx_at(1)); end
    tick(2);
    send_rx(8'hFA);
  endtask

  task automatic test_forward_pending();
    clear_q();
    leds = 3'b101;
    pulse_led();
    wait_tx(1);
    tick(2);
    send_rx(8'hFA);
    wait_tx(2);
    tick(2);
    leds    = 3'b010;
    rxData  = 8'h1C;
    rxValid = 1'b1;
    ledReq  = 1'b1;
    n_cmp++; if (keyValid !== 1'b0) begin n_fail++; $display("FAIL fwd_kv_before: got %b expected 0", keyValid); end
    tick(1);
    rxValid = 1'b0;
    ledReq  = 1'b0;
    n_cmp++; if (keyValid !== 1'b1) begin n_fail++; $display("FAIL fwd_kv: got %b expected 1", keyValid); end
    n_cmp++; if (keyData !== 8'h1C) begin n_fail++; $display("FAIL fwd_kd: got %h expected 1C", keyData); end
    tick(1);
    n_cmp++; if (keyValid !== 1'b0) begin n_fail++; $display("FAIL fwd_kv_pulse: got %b expected 0", keyValid); end
    tick(1);
    send_rx(8'hFA);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pend_idle: got %b expected 0", busy); end
    tick(1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pend_start: got %b expected 1", busy); end
    wait_tx(3);
    n_cmp++; if (tx_at(2) !== 8'hED) begin n_fail++; $display("FAIL pend_cmd: got %h expected ED", tx_at(2)); end
    tick(2);
    send_rx(8'hFA);
    wait_tx(4);
    n_cmp++; if (tx_at(3) !== 8'h02) begin n_fail++; $display("FAIL pend_arg: got %h expected 02", tx_at(3)); end
    tick(2);
    send_rx(8'hFA);
    tick(3);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pend_done: got %b expected 0", busy); end
    n_cmp++; if (tx_q.size() !== 4) begin n_fail++; $display("FAIL pend_single: got %0d expected 4", tx_q.size()); end
  endtask

  task automatic test_same_cycle();
    clear_q();
    rxData  = 8'h5A;
    rxValid = 1'b1;
    ledReq  = 1'b1;
    tick(1);
    rxValid = 1'b0;
    ledReq  = 1'b0;
    n_cmp++; if (keyValid !== 1'b1) begin n_fail++; $display("FAIL same_kv: got %b expected 1", keyValid); end
    n_cmp++; if (keyData !== 8'h5A) begin n_fail++; $display("FAIL same_kd: got %h expected 5A", keyData); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL same_busy: got %b expected 1", busy); end
    wait_tx(1);
    tick(2);
    send_rx(8'hFA);
    wait_tx(2);
    n_cmp++; if (tx_at(1) !== 8'h02) begin n_fail++; $display("FAIL same_arg: got %h expected 02", tx_at(1)); end
    tick(2);
    send_rx(8'hFA);
  endtask

  task automatic test_tx_busy_hold();
    clear_q();
    txBusy = 1'b1;
    pulse_led();
    tick(10);
    n_cmp++; if (tx_q.size() !== 0) begin n_fail++; $display("FAIL txbusy_hold: got %0d expected 0", tx_q.size()); end
    txBusy = 1'b0;
    wait_tx(1);
    n_cmp++; if (tx_at(0) !== 8'hED) begin n_fail++; $display("FAIL txbusy_release: got %h expected ED", tx_at(0)); end
    tick(2);
    send_rx(8'hFA);
    wait_tx(2);
    tick(2);
    send_rx(8'hFA);
  endtask

  task automatic test_reset_abort();
    int extra;
    logic exp_busy;
`ifdef PS2_HOST_INIT_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    clear_q();
    pulse_led();
    wait_tx(1);
    tick(2);
    reset = 1'b1;
    tick(2);
    n_cmp++; if (keyData !== 8'h00) begin n_fail++; $display("FAIL abort_keyData: got %h expected 00", keyData); end
    n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL abort_busy: got %b expected %b", busy, exp_busy); end
    reset = 1'b0;
`ifndef PS2_HOST_INIT_EN
    tick(2);
    send_rx(8'hFA);
`endif
    tick(30);
    extra = 0;
    for (int i = 1; i < tx_q.size(); i++) if (tx_q[i] !== 8'hFF) extra++;
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL abort_no_tx: got %0d extra bytes expected 0", extra); end
  endtask

  initial begin
    tick(1);
    test_reset();
`ifdef PS2_HOST_INIT_EN
    test_init();
`endif
    test_led_update();
    test_resend();
    test_retry_exhaust();
    test_timeout();
    test_ack_at_expiry();
    test_forward_pending();
    test_same_cycle();
    test_tx_busy_hold();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
